// File: rtl/phase_seq_gen_if.sv
// phase_seq_gen_if
//   Bundles the control inputs and phase outputs of phase_seq_gen.
//   Signals:
//     en        run enable (sequencer -> generator)
//     ack       shared datapath completion (datapath -> generator)
//     skip_mask per-phase skip bits, bit 0 ignored
//     ph        dual-rail phase pairs, pair i = ph[2i+1:2i]
//     cur       index of the phase holding the token
//     wrap      one-cycle pulse when the token returns to phase 0
//     err       sticky handshake timeout flag
//   Modports:
//     master    the generator itself
//     slave     the surrounding sequencer/datapath
interface phase_seq_gen_if #(
  parameter int N_PH = 3,
  parameter int IDXW = (N_PH > 1) ? $clog2(N_PH) : 1
);
  logic                en;
  logic                ack;
  logic [N_PH-1:0]     skip_mask;
  logic [2*N_PH-1:0]   ph;
  logic [IDXW-1:0]     cur;
  logic                wrap;
  logic                err;

  modport master (
    input  en, ack, skip_mask,
    output ph, cur, wrap, err
  );

  modport slave (
    output en, ack, skip_mask,
    input  ph, cur, wrap, err
  );
endinterface

// File: rtl/phase_seq_gen.sv
// phase_seq_gen
//   Circulates a single active token over N_PH dual-rail phase outputs using
//   a four-phase return-to-zero handshake against one shared ack. A NULL
//   spacer of GAP cycles follows each handshake; phases whose skip_mask bit
//   is set are bypassed (phase 0 never is). All outputs are registered.
//   Optional feature macro: PHASE_GEN_TIMEOUT_EN -- builds a handshake
//   watchdog that sets the sticky err flag after TIMEOUT waiting cycles.
//   Without it err is tied low and TIMEOUT is unused.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   phase_seq_gen_if.master (en, ack, skip_mask in; ph, cur, wrap, err out)
module phase_seq_gen #(
  parameter int N_PH    = 3,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  phase_seq_gen_if.master    bus
);
  localparam int         IDXW     = (N_PH > 1) ? $clog2(N_PH) : 1;
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, DATA, NUL, GAPW} state_t;

  state_t              r_state;
  logic [2*N_PH-1:0]   r_ph;
  logic [IDXW-1:0]     r_cur;
  logic                r_wrap;
  logic                r_wrap_pend;
  logic [3:0]          r_gap_cnt;

  logic [IDXW-1:0]     w_next_cur;
  logic                w_found;

  // Codeword with pair idx active (10) and every other pair DATA0 (01).
  function automatic logic [2*N_PH-1:0] codeword(input logic [IDXW-1:0] idx);
    logic [2*N_PH-1:0] cw;
    cw = '0;
    for (int unsigned i = 0; i < N_PH; i++) begin
      cw[2*i +: 2] = (IDXW'(i) == idx) ? 2'b10 : 2'b01;
    end
    return cw;
  endfunction

  // First unskipped phase above cur; falls back to 0 when none remains.
  always_comb begin
    w_next_cur = '0;
    w_found    = 1'b0;
    for (int unsigned k = 1; k < N_PH; k++) begin
      if (!w_found && (32'(r_cur) + k) < 32'(N_PH)) begin
        if (!bus.skip_mask[IDXW'(32'(r_cur) + k)]) begin
          w_next_cur = IDXW'(32'(r_cur) + k);
          w_found    = 1'b1;
        end
      end
    end
  end

  // r_wrap_pend remembers that the last advance landed on phase 0 so the
  // pulse can be issued with the next phase-0 codeword, after a gap or pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ph        <= '0;
      r_cur       <= '0;
      r_wrap      <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state     <= DATA;
            r_ph        <= codeword(r_cur);
            r_wrap      <= r_wrap_pend;
            r_wrap_pend <= 1'b0;
          end
        end
        DATA: begin
          if (bus.ack) begin
            r_state <= NUL;
            r_ph    <= '0;
          end
        end
        NUL: begin
          if (!bus.ack) begin
            r_cur <= w_next_cur;
            if (GAP > 0) begin
              r_state     <= GAPW;
              r_gap_cnt   <= '0;
              r_wrap_pend <= (w_next_cur == '0);
            end else if (bus.en) begin
              r_state <= DATA;
              r_ph    <= codeword(w_next_cur);
              r_wrap  <= (w_next_cur == '0);
            end else begin
              r_state     <= IDLE;
              r_wrap_pend <= (w_next_cur == '0);
            end
          end
        end
        GAPW: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            if (bus.en) begin
              r_state     <= DATA;
              r_ph        <= codeword(r_cur);
              r_wrap      <= r_wrap_pend;
              r_wrap_pend <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ph   = r_ph;
  assign bus.cur  = r_cur;
  assign bus.wrap = r_wrap;

`ifdef PHASE_GEN_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 2);

  logic [TOW-1:0] r_to_cnt;
  logic           r_err;
  logic           w_waiting;

  // Still waiting after this edge: no state change out of DATA or NUL.
  assign w_waiting = ((r_state == DATA) && !bus.ack) || ((r_state == NUL) && bus.ack);

  // r_to_cnt holds completed waiting cycles; err is set at the edge that
  // ends waiting cycle TIMEOUT-1 so it is visible in cycle TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else if (w_waiting) begin
      if (32'(r_to_cnt) < 32'(TIMEOUT)) r_to_cnt <= r_to_cnt + 1'b1;
      if ((32'(r_to_cnt) + 32'd2) >= 32'(TIMEOUT)) r_err <= 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_phase_seq_gen.sv
module tb_phase_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   echo = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  phase_seq_gen_if #(.N_PH(3)) bus3 ();
  phase_seq_gen_if #(.N_PH(8)) bus8 ();

  phase_seq_gen #(.N_PH(3), .GAP(1), .TIMEOUT(64)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  phase_seq_gen #(.N_PH(8), .GAP(0), .TIMEOUT(64)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  // Reference: next phase is the smallest member of the active ring
  // {0} + {unmasked phases} above cur, else back to 0.
  function automatic int ref_next(int cur, logic [7:0] mask, int n);
    int ring[$];
    ring.push_back(0);
    for (int i = 1; i < n; i++) if (!mask[i]) ring.push_back(i);
    foreach (ring[j]) if (ring[j] > cur) return ring[j];
    return 0;
  endfunction

  // Reference codeword: all pairs 01, then adding 01 to pair idx makes it 10.
  function automatic logic [15:0] ref_cw(int idx, int n);
    logic [31:0] v;
    v = (32'h5555 & ((32'd1 << (2*n)) - 32'd1)) + (32'd1 << (2*idx));
    return v[15:0];
  endfunction

  function automatic logic [15:0] rd_ph(int d);
    return (d == 0) ? 16'(bus3.ph) : bus8.ph;
  endfunction
  function automatic int rd_cur(int d);
    return (d == 0) ? int'(bus3.cur) : int'(bus8.cur);
  endfunction
  function automatic logic rd_wrap(int d);
    return (d == 0) ? bus3.wrap : bus8.wrap;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (echo) begin
      bus3.ack = |bus3.ph;
      bus8.ack = |bus8.ph;
    end
  endtask

  task automatic reset_dut();
    bus3.en = 1'b0; bus8.en = 1'b0;
    bus3.ack = 1'b0; bus8.ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Advance to the next codeword start (non-NULL after NULL), bounded.
  // bad flags a 2'b11 pair, a direct codeword change or wrap outside a start.
  task automatic wait_cw(input int d, output int cyc, output bit found, output bit bad);
    logic [15:0] w, prev;
    bit seen_null;
    prev = rd_ph(d); seen_null = (prev == 16'h0);
    found = 1'b0; bad = 1'b0; cyc = 0;
    while (!found && cyc < 200) begin
      tick(); cyc++;
      w = rd_ph(d);
      for (int i = 0; i < 8; i++) if (w[2*i +: 2] == 2'b11) bad = 1'b1;
      if (w == 16'h0) begin
        seen_null = 1'b1;
        if (rd_wrap(d)) bad = 1'b1;
      end else if (seen_null) found = 1'b1;
      else if (w != prev) bad = 1'b1;
      prev = w;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++; if (rd_ph(0) !== 16'h0) $display("FAIL reset_ph3 got=%h exp=0", rd_ph(0)); else pass_cnt++;
    total_cnt++; if (rd_cur(0) !== 0) $display("FAIL reset_cur3 got=%0d exp=0", rd_cur(0)); else pass_cnt++;
    total_cnt++; if (bus3.wrap !== 1'b0) $display("FAIL reset_wrap3 got=%b exp=0", bus3.wrap); else pass_cnt++;
    total_cnt++; if (bus3.err !== 1'b0) $display("FAIL reset_err3 got=%b exp=0", bus3.err); else pass_cnt++;
    total_cnt++; if (rd_ph(1) !== 16'h0) $display("FAIL reset_ph8 got=%h exp=0", rd_ph(1)); else pass_cnt++;
    total_cnt++; if (rd_cur(1) !== 0) $display("FAIL reset_cur8 got=%0d exp=0", rd_cur(1)); else pass_cnt++;
    total_cnt++; if (bus8.wrap !== 1'b0) $display("FAIL reset_wrap8 got=%b exp=0", bus8.wrap); else pass_cnt++;
    total_cnt++; if (bus8.err !== 1'b0) $display("FAIL reset_err8 got=%b exp=0", bus8.err); else pass_cnt++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_ring();
    int cyc, exp; bit found, bad, ew;
    reset_dut();
    bus3.skip_mask = '0; bus3.en = 1'b1; exp = 0;
    for (int n = 0; n < 7; n++) begin
      wait_cw(0, cyc, found, bad);
      ew = (exp == 0 && n > 0);
      total_cnt++; if (!found || bad) $display("FAIL ring_stream[%0d] found=%b bad=%b exp found=1 bad=0", n, found, bad); else pass_cnt++;
      total_cnt++; if (rd_ph(0) !== ref_cw(exp, 3)) $display("FAIL ring_ph[%0d] got=%h exp=%h", n, rd_ph(0), ref_cw(exp, 3)); else pass_cnt++;
      total_cnt++; if (rd_cur(0) !== exp) $display("FAIL ring_cur[%0d] got=%0d exp=%0d", n, rd_cur(0), exp); else pass_cnt++;
      total_cnt++; if (rd_wrap(0) !== ew) $display("FAIL ring_wrap[%0d] got=%b exp=%b", n, rd_wrap(0), ew); else pass_cnt++;
      if (n > 0) begin
        total_cnt++; if (cyc !== 3) $display("FAIL ring_period[%0d] got=%0d exp=3", n, cyc); else pass_cnt++;
      end
      exp = ref_next(exp, 8'h00, 3);
    end
  endtask

  task automatic test_skip();
    int cyc; bit found, bad;
    int  exp_cur[8]  = '{0, 2, 0, 2, 0, 0, 0, 0};
    bit  exp_wrap[8] = '{0, 0, 1, 0, 1, 1, 1, 1};
    reset_dut();
    bus3.skip_mask = 3'b010; bus3.en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_cw(0, cyc, found, bad);
      total_cnt++; if (!found || bad) $display("FAIL skip_stream[%0d] found=%b bad=%b exp found=1 bad=0", n, found, bad); else pass_cnt++;
      total_cnt++; if (rd_cur(0) !== exp_cur[n]) $display("FAIL skip_cur[%0d] got=%0d exp=%0d", n, rd_cur(0), exp_cur[n]); else pass_cnt++;
      total_cnt++; if (rd_ph(0) !== ref_cw(exp_cur[n], 3)) $display("FAIL skip_ph[%0d] got=%h exp=%h", n, rd_ph(0), ref_cw(exp_cur[n], 3)); else pass_cnt++;
      total_cnt++; if (rd_wrap(0) !== exp_wrap[n]) $display("FAIL skip_wrap[%0d] got=%b exp=%b", n, rd_wrap(0), exp_wrap[n]); else pass_cnt++;
      if (n == 3) bus3.skip_mask = 3'b110;
    end
  endtask

  task automatic test_random();
    int cyc, exp; bit found, bad, ew; logic [2:0] m;
    reset_dut();
    bus3.skip_mask = 3'($urandom); bus3.en = 1'b1; exp = 0;
    for (int n = 0; n < 24; n++) begin
      m = bus3.skip_mask;
      wait_cw(0, cyc, found, bad);
      ew = (exp == 0 && n > 0);
      total_cnt++; if (!found || bad) $display("FAIL rand_stream[%0d] found=%b bad=%b exp found=1 bad=0", n, found, bad); else pass_cnt++;
      total_cnt++; if (rd_cur(0) !== exp) $display("FAIL rand_cur[%0d] got=%0d exp=%0d mask=%b", n, rd_cur(0), exp, m); else pass_cnt++;
      total_cnt++; if (rd_ph(0) !== ref_cw(exp, 3)) $display("FAIL rand_ph[%0d] got=%h exp=%h", n, rd_ph(0), ref_cw(exp, 3)); else pass_cnt++;
      total_cnt++; if (rd_wrap(0) !== ew) $display("FAIL rand_wrap[%0d] got=%b exp=%b", n, rd_wrap(0), ew); else pass_cnt++;
      if (n > 0) begin
        total_cnt++; if (cyc !== 3) $display("FAIL rand_period[%0d] got=%0d exp=3", n, cyc); else pass_cnt++;
      end
      // new mask is sampled at the advance that ends this codeword
      bus3.skip_mask = 3'($urandom);
      exp = ref_next(exp, 8'(bus3.skip_mask), 3);
    end
  endtask

  task automatic test_pause();
    int cyc; bit found, bad;
    reset_dut();
    bus3.skip_mask = '0; bus3.en = 1'b1;
    wait_cw(0, cyc, found, bad);
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (rd_cur(0) !== 1) $display("FAIL pause_pre_cur got=%0d exp=1", rd_cur(0)); else pass_cnt++;
    bus3.en = 1'b0;
    repeat (8) tick();
    total_cnt++; if (rd_ph(0) !== 16'h0) $display("FAIL pause_idle_ph got=%h exp=0", rd_ph(0)); else pass_cnt++;
    total_cnt++; if (rd_cur(0) !== 2) $display("FAIL pause_idle_cur got=%0d exp=2", rd_cur(0)); else pass_cnt++;
    bus3.en = 1'b1;
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (!found || bad || cyc !== 1) $display("FAIL pause_resume found=%b bad=%b cyc=%0d exp 1/0/1", found, bad, cyc); else pass_cnt++;
    total_cnt++; if (rd_ph(0) !== ref_cw(2, 3)) $display("FAIL pause_resume_ph got=%h exp=%h", rd_ph(0), ref_cw(2, 3)); else pass_cnt++;
    total_cnt++; if (rd_wrap(0) !== 1'b0) $display("FAIL pause_resume_wrap got=%b exp=0", rd_wrap(0)); else pass_cnt++;
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (rd_cur(0) !== 0 || rd_wrap(0) !== 1'b1) $display("FAIL pause_next cur=%0d wrap=%b exp cur=0 wrap=1", rd_cur(0), rd_wrap(0)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit found, bad;
    reset_dut();
    bus3.skip_mask = '0; bus3.en = 1'b1;
    wait_cw(0, cyc, found, bad);
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (rd_ph(0) !== ref_cw(1, 3)) $display("FAIL mid_pre_ph got=%h exp=%h", rd_ph(0), ref_cw(1, 3)); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (rd_ph(0) !== 16'h0) $display("FAIL mid_async_ph got=%h exp=0", rd_ph(0)); else pass_cnt++;
    total_cnt++; if (rd_cur(0) !== 0) $display("FAIL mid_async_cur got=%0d exp=0", rd_cur(0)); else pass_cnt++;
    total_cnt++; if (rd_wrap(0) !== 1'b0) $display("FAIL mid_async_wrap got=%b exp=0", rd_wrap(0)); else pass_cnt++;
    #1 rst = 1'b0;
    bus3.ack = 1'b0;
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (!found || bad) $display("FAIL mid_restart found=%b bad=%b exp 1/0", found, bad); else pass_cnt++;
    total_cnt++; if (rd_ph(0) !== ref_cw(0, 3)) $display("FAIL mid_restart_ph got=%h exp=%h", rd_ph(0), ref_cw(0, 3)); else pass_cnt++;
    total_cnt++; if (rd_wrap(0) !== 1'b0) $display("FAIL mid_restart_wrap got=%b exp=0", rd_wrap(0)); else pass_cnt++;
  endtask

  task automatic test_n8();
    int cyc, exp; bit found, bad, ew;
    reset_dut();
    bus8.skip_mask = '0; bus8.en = 1'b1; exp = 0;
    for (int n = 0; n < 22; n++) begin
      wait_cw(1, cyc, found, bad);
      ew = (exp == 0 && n > 0);
      total_cnt++; if (!found || bad) $display("FAIL n8_stream[%0d] found=%b bad=%b exp found=1 bad=0", n, found, bad); else pass_cnt++;
      total_cnt++; if (rd_cur(1) !== exp) $display("FAIL n8_cur[%0d] got=%0d exp=%0d", n, rd_cur(1), exp); else pass_cnt++;
      total_cnt++; if (rd_ph(1) !== ref_cw(exp, 8)) $display("FAIL n8_ph[%0d] got=%h exp=%h", n, rd_ph(1), ref_cw(exp, 8)); else pass_cnt++;
      total_cnt++; if (rd_wrap(1) !== ew) $display("FAIL n8_wrap[%0d] got=%b exp=%b", n, rd_wrap(1), ew); else pass_cnt++;
      if (n > 0) begin
        total_cnt++; if (cyc !== 2) $display("FAIL n8_period[%0d] got=%0d exp=2", n, cyc); else pass_cnt++;
      end
      // full ring first (covers 7->0), then random masks
      if (n >= 9) bus8.skip_mask = 8'($urandom);
      exp = ref_next(exp, bus8.skip_mask, 8);
    end
    bus8.en = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc; bit found, bad;
    reset_dut();
    echo = 1'b0;
    bus3.skip_mask = '0; bus3.en = 1'b1; bus3.ack = 1'b0;
    wait_cw(0, cyc, found, bad);
    repeat (62) tick();
`ifdef PHASE_GEN_TIMEOUT_EN
    total_cnt++; if (bus3.err !== 1'b0) $display("FAIL to_cycle63 got=%b exp=0", bus3.err); else pass_cnt++;
    tick();
    total_cnt++; if (bus3.err !== 1'b1) $display("FAIL to_cycle64 got=%b exp=1", bus3.err); else pass_cnt++;
    repeat (10) tick();
    total_cnt++; if (bus3.err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", bus3.err); else pass_cnt++;
`else
    repeat (40) tick();
    total_cnt++; if (bus3.err !== 1'b0) $display("FAIL to_disabled_err got=%b exp=0", bus3.err); else pass_cnt++;
`endif
    total_cnt++; if (rd_ph(0) !== ref_cw(0, 3)) $display("FAIL to_waiting_ph got=%h exp=%h", rd_ph(0), ref_cw(0, 3)); else pass_cnt++;
    bus3.ack = 1'b1;
    tick();
    bus3.ack = 1'b0;
    echo = 1'b1;
    wait_cw(0, cyc, found, bad);
    total_cnt++; if (!found || rd_ph(0) !== ref_cw(1, 3)) $display("FAIL to_resume found=%b ph=%h exp ph=%h", found, rd_ph(0), ref_cw(1, 3)); else pass_cnt++;
`ifdef PHASE_GEN_TIMEOUT_EN
    total_cnt++; if (bus3.err !== 1'b1) $display("FAIL to_after_ack got=%b exp=1", bus3.err); else pass_cnt++;
`else
    total_cnt++; if (bus3.err !== 1'b0) $display("FAIL to_after_ack got=%b exp=0", bus3.err); else pass_cnt++;
`endif
  endtask

  initial begin
    bus3.en = 1'b0; bus3.ack = 1'b0; bus3.skip_mask = '0;
    bus8.en = 1'b0; bus8.ack = 1'b0; bus8.skip_mask = '0;
    #1;
    test_reset();
    test_ring();
    test_skip();
    test_random();
    test_pause();
    test_reset_mid();
    test_n8();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
